clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Time-setting front end for the digit counter chain: drives each decade digit's write
//  port (write strobe + 4-bit value) from four push buttons, and gates normal counting.
//  Debounces the raw buttons, selects a digit, and writes value+1 / value-1 with
//  per-digit wrap. Sits between the board buttons and the clock digit counters.
// PARAMETERS
//  N_DIGITS        6          number of BCD digits controlled; digit 0 = LSB
//  DIGIT_MAX       24'h295959 packed per-digit max, 4 bits/digit, digit0 in [3:0]
//  DEBOUNCE_TICKS  8          consecutive equal i_tick samples to accept a level (>=2)
//  SET_TIMEOUT     10000      i_tick count with no accepted press before auto-exit; 0 = never
//  REPEAT_DELAY    500        i_tick count held before first auto-repeat (AUTOREPEAT_EN only)
//  REPEAT_PERIOD   150        i_tick count between auto-repeats (AUTOREPEAT_EN only)
// PORTS
//  i_clk        in   1            system clock
//  i_reset      in   1            synchronous, active-high reset
//  i_tick       in   1            1-cycle sample strobe (e.g. 1 kHz)
//  i_btn_mode   in   1            raw async button: enter/exit set mode
//  i_btn_next   in   1            raw async button: select next digit
//  i_btn_inc    in   1            raw async button: increment selected digit
//  i_btn_dec    in   1            raw async button: decrement selected digit
//  i_digits     in   4*N_DIGITS   current counter values, digit0 in [3:0]
//  o_run        out  1            1 = normal counting allowed; 0 while setting
//  o_sel        out  N_DIGITS     one-hot selected digit (display blink); 0 in RUN
//  o_wr         out  N_DIGITS     one-hot 1-cycle write strobe to a digit counter
//  o_wr_data    out  4            value to write; valid only while |o_wr
// BEHAVIOUR
//  - Reset (synchronous, active-high, on i_clk): state RUN, o_run=1, o_sel=0, o_wr=0,
//    o_wr_data=0, debounced levels=0, timeout/repeat counters=0; mid-write is aborted.
//  - Debounce: 2-FF synchroniser per button; level updates only on i_tick, after
//    DEBOUNCE_TICKS consecutive equal samples. Press event = 0->1 of debounced level,
//    1 cycle wide. Button held through reset yields one press once debounced.
//  - States: RUN, SET, WRITE. All outputs registered.
//    RUN:  mode press -> SET, o_run=0, o_sel=one-hot MSB digit. Other presses ignored.
//    SET:  mode press -> RUN (o_run=1, o_sel=0). next press -> o_sel moves one digit toward
//          LSB; LSB wraps to MSB. inc/dec press -> WRITE.
//          timeout counter (SET_TIMEOUT>0) counts i_tick, clears on any press; at
//          SET_TIMEOUT -> RUN exactly as for mode press.
//    WRITE: single cycle: o_wr=o_sel, o_wr_data computed from selected i_digits nibble v,
//          max m: inc: v>=m ? 0 : v+1; dec: v==0 ? m : (v>m ? m : v-1). Then -> SET.
//  - Latency: press event in cycle N -> o_wr high in cycle N+1, low in N+2.
//  - Simultaneous presses same cycle: priority mode > next > inc > dec; losers dropped.
//  - Press arriving during WRITE is dropped (no queueing).
//  - Integration: counter enable = (o_run & second_tick) | o_wr[k]; counters see no
//    up/down while o_run=0.
// CONFIGURATION
//  - Macro CLOCK_SET_AUTOREPEAT_EN defined: inc/dec held in SET emits first repeat event
//    REPEAT_DELAY ticks after its press, then every REPEAT_PERIOD ticks while held; a
//    repeat counts as a press (resets timeout). Release or leaving SET stops repeat.
//  - Not defined: exactly one event per press; repeat counters and parameters unused.
// STRUCTURE
//  - Package clock_set_pkg: state enum (RUN/SET/WRITE), button index constants
//    (BTN_MODE=0, BTN_NEXT=1, BTN_INC=2, BTN_DEC=3), NIBBLE_W=4.
//  - Sub-module button_debounce (sync + tick-counted filter + edge detect), one per
//    button, 4 instances; FSM, digit select and wrap arithmetic in the top.
// TESTING (N_DIGITS=6, DIGIT_MAX=24'h295959, DEBOUNCE_TICKS=4, SET_TIMEOUT=50)
//  - Reset, hold mode 4 ticks -> o_run=0, o_sel=6'b100000 one cycle after debounce edge.
//  - SET, digit5=2, press inc -> o_wr=6'b100000, o_wr_data=4'h0 for exactly 1 cycle.
//  - SET, 5 next presses -> o_sel=6'b000001; 6th -> 6'b100000 (wrap).
//  - sel digit0, value 0, press dec -> o_wr_data=4'h9; sel digit1 value 4'hC, inc -> 4'h0.
//  - inc toggled every tick for 3 ticks then released -> no o_wr; inc+dec pressed
//    together -> one write, increment only.
//  - SET, no presses 50 ticks -> o_run=1, o_sel=0; with CLOCK_SET_AUTOREPEAT_EN, inc held
//    REPEAT_DELAY+2*REPEAT_PERIOD ticks -> exactly 4 o_wr pulses.

Source files
------------

// File: rtl/clock_set_pkg.sv
// clock_set_pkg: shared states, button indices and widths for the clock time-setting front end
package clock_set_pkg;
  typedef enum logic [1:0] {RUN, SET, WRITE} state_t;
  localparam int BTN_MODE = 0;
  localparam int BTN_NEXT = 1;
  localparam int BTN_INC = 2;
  localparam int BTN_DEC = 3;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchroniser, tick-counted level filter and 1-cycle rising-edge press
module button_debounce #(
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_TICKS);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync <= '0;
      cnt <= '0;
      o_level <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync <= {sync[0], i_btn};
      level_d <= o_level;
      if (i_tick) begin
        if (sync[1] == o_level) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
          o_level <= sync[1];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
  assign o_press = o_level & ~level_d;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven digit select/write front end; CLOCK_SET_AUTOREPEAT_EN adds inc/dec auto-repeat
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter logic [4*N_DIGITS-1:0] DIGIT_MAX = 24'h295959,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int SET_TIMEOUT = 10000
`ifdef CLOCK_SET_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_PERIOD = 150
`endif
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_btn_mode,
  input  logic i_btn_next,
  input  logic i_btn_inc,
  input  logic i_btn_dec,
  input  logic [4*N_DIGITS-1:0] i_digits,
  output logic o_run,
  output logic [N_DIGITS-1:0] o_sel,
  output logic [N_DIGITS-1:0] o_wr,
  output logic [NIBBLE_W-1:0] o_wr_data
);
  localparam logic [N_DIGITS-1:0] SEL_MSB = {1'b1, {(N_DIGITS-1){1'b0}}};
  localparam int TW = SET_TIMEOUT > 0 ? $clog2(SET_TIMEOUT + 1) : 1;
  logic [3:0] raw, lvl, prs, ev;
  logic unused_lvl;
  state_t state, state_n;
  logic run_n;
  logic [N_DIGITS-1:0] sel_n, wr_n;
  logic [NIBBLE_W-1:0] wr_data_n, v, m;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [TW:0] tcnt_inc;
  logic to_hit;
  assign raw = {i_btn_dec, i_btn_inc, i_btn_next, i_btn_mode};
  for (genvar g = 0; g < 4; g++) begin : g_db
    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_tick(i_tick),
      .i_btn(raw[g]),
      .o_level(lvl[g]),
      .o_press(prs[g])
    );
  end
`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [1:0] rep_btn, rep_btn_n;
  logic rep_first, rep_first_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [3:0] rep_ev;
  // rep_btn: bit0 = inc held, bit1 = dec held; repeats fire as synthetic presses
  always_comb begin
    rep_btn_n = rep_btn;
    rep_first_n = rep_first;
    rcnt_n = rcnt;
    rep_ev = '0;
    if (state == RUN || (rep_btn & lvl[BTN_DEC:BTN_INC]) == 2'b00) begin
      rep_btn_n = '0;
      rcnt_n = '0;
    end else if (i_tick) begin
      rcnt_n = rcnt + 1'b1;
      if (rcnt_n == RW'(rep_first ? REPEAT_DELAY : REPEAT_PERIOD)) begin
        rep_ev[BTN_INC] = rep_btn[0];
        rep_ev[BTN_DEC] = rep_btn[1];
        rcnt_n = '0;
        rep_first_n = 1'b0;
      end
    end
    if (state == SET && !prs[BTN_MODE] && !prs[BTN_NEXT] && (prs[BTN_INC] | prs[BTN_DEC])) begin
      rep_btn_n = prs[BTN_INC] ? 2'b01 : 2'b10;
      rcnt_n = '0;
      rep_first_n = 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rep_btn <= '0;
      rep_first <= 1'b0;
      rcnt <= '0;
    end else begin
      rep_btn <= rep_btn_n;
      rep_first <= rep_first_n;
      rcnt <= rcnt_n;
    end
  end
  assign ev = prs | rep_ev;
  assign unused_lvl = ^lvl[BTN_NEXT:BTN_MODE];
`else
  assign ev = prs;
  assign unused_lvl = ^lvl;
`endif
  assign tcnt_inc = {1'b0, tcnt} + 1'b1;
  assign to_hit = SET_TIMEOUT > 0 && tcnt_inc >= (TW+1)'(SET_TIMEOUT);
  always_comb begin
    state_n = state;
    run_n = o_run;
    sel_n = o_sel;
    wr_n = '0;
    wr_data_n = o_wr_data;
    tcnt_n = tcnt;
    v = '0;
    m = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (o_sel[k]) begin
        v = i_digits[k*NIBBLE_W +: NIBBLE_W];
        m = DIGIT_MAX[k*NIBBLE_W +: NIBBLE_W];
      end
    end
    unique case (state)
      RUN: if (ev[BTN_MODE]) begin
        state_n = SET;
        run_n = 1'b0;
        sel_n = SEL_MSB;
        tcnt_n = '0;
      end
      SET: if (|ev) begin
        tcnt_n = '0;
        if (ev[BTN_MODE]) begin
          state_n = RUN;
          run_n = 1'b1;
          sel_n = '0;
        end else if (ev[BTN_NEXT]) sel_n = {o_sel[0], o_sel[N_DIGITS-1:1]};
        else begin
          state_n = WRITE;
          wr_n = o_sel;
          wr_data_n = ev[BTN_INC] ? ((v >= m) ? '0 : v + 4'd1)
                                  : ((v == '0) ? m : ((v > m) ? m : v - 4'd1));
        end
      end else if (i_tick && SET_TIMEOUT > 0) begin
        if (to_hit) begin
          state_n = RUN;
          run_n = 1'b1;
          sel_n = '0;
          tcnt_n = '0;
        end else tcnt_n = tcnt_inc[TW-1:0];
      end
      WRITE: begin
        state_n = SET;
        if (i_tick && SET_TIMEOUT > 0) tcnt_n = tcnt_inc[TW-1:0];
      end
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= RUN;
      o_run <= 1'b1;
      o_sel <= '0;
      o_wr <= '0;
      o_wr_data <= '0;
      tcnt <= '0;
    end else begin
      state <= state_n;
      o_run <= run_n;
      o_sel <= sel_n;
      o_wr <= wr_n;
      o_wr_data <= wr_data_n;
      tcnt <= tcnt_n;
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed + randomized bench against a behavioural model of clock_set_ctrl
module tb_clock_set_ctrl;
  localparam int N = 6;
  localparam int DB = 4;
  localparam int TO = 50;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam logic [23:0] DMAX = 24'h295959;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic bm = 1'b0, bn = 1'b0, bi = 1'b0, bd = 1'b0;
  logic [23:0] digits = '0;
  logic o_run;
  logic [N-1:0] o_sel, o_wr;
  logic [3:0] o_wr_data;
  int total = 0, bad = 0, cyc = 0, wr_cycles = 0;
  logic [N-1:0] last_wr = '0;
  logic [3:0] last_data = '0;
  bit checking = 0;
  bit setting = 0, wr = 0;
  int sel = 0, tc = 0;
  logic [3:0] data = '0;
  bit lvl[4], lvl_d[4], p0[4], p1[4];
  bit q[4][$];

  clock_set_ctrl #(
    .N_DIGITS(N), .DIGIT_MAX(DMAX), .DEBOUNCE_TICKS(DB), .SET_TIMEOUT(TO)
`ifdef CLOCK_SET_AUTOREPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_tick(tick),
    .i_btn_mode(bm), .i_btn_next(bn), .i_btn_inc(bi), .i_btn_dec(bd),
    .i_digits(digits), .o_run(o_run), .o_sel(o_sel), .o_wr(o_wr), .o_wr_data(o_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a level is accepted once the last DB tick samples all agree and differ from it.
  task automatic model_step();
    bit pr[4];
    bit raw[4];
    bit same;
    logic [23:0] dm;
    logic [3:0] v, m;
    raw = '{bm, bn, bi, bd};
    if (rst) begin
      setting = 0; wr = 0; sel = 0; tc = 0; data = '0;
      for (int b = 0; b < 4; b++) begin
        lvl[b] = 0; lvl_d[b] = 0; p0[b] = 0; p1[b] = 0; q[b].delete();
      end
      return;
    end
    for (int b = 0; b < 4; b++) pr[b] = lvl[b] & !lvl_d[b];
    dm = DMAX;
    v = digits[sel*4 +: 4];
    m = dm[sel*4 +: 4];
    if (wr) begin
      wr = 0;
      if (tick) tc++;
    end else if (!setting) begin
      if (pr[0]) begin setting = 1; sel = N - 1; tc = 0; end
    end else if (pr[0] | pr[1] | pr[2] | pr[3]) begin
      tc = 0;
      if (pr[0]) setting = 0;
      else if (pr[1]) sel = (sel == 0) ? N - 1 : sel - 1;
      else begin
        wr = 1;
        if (pr[2]) data = (v >= m) ? 4'd0 : 4'(v + 1);
        else data = (v == 0) ? m : ((v > m) ? m : 4'(v - 1));
      end
    end else if (tick) begin
      if (tc + 1 >= TO) begin setting = 0; tc = 0; end
      else tc++;
    end
    for (int b = 0; b < 4; b++) begin
      lvl_d[b] = lvl[b];
      if (tick) begin
        q[b].push_back(p1[b]);
        if (q[b].size() > DB) void'(q[b].pop_front());
        same = (q[b].size() == DB);
        foreach (q[b][i]) if (q[b][i] != q[b][0]) same = 0;
        if (same && q[b][0] != lvl[b]) lvl[b] = q[b][0];
      end
      p1[b] = p0[b];
      p0[b] = raw[b];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (|o_wr) begin wr_cycles++; last_wr = o_wr; last_data = o_wr_data; end
    if (checking) begin
      chk("run", {31'b0, o_run}, {31'b0, !setting});
      chk("sel", 32'(o_sel), setting ? 32'(1 << sel) : 32'd0);
      chk("wr", 32'(o_wr), wr ? 32'(1 << sel) : 32'd0);
      if (wr) chk("wr_data", 32'(o_wr_data), 32'(data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick = (cyc % 4 == 0);
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      step();
      if (tick) k++;
    end
  endtask

  task automatic press(input logic [3:0] b);
    {bd, bi, bn, bm} = b;
    wait_ticks(6);
    {bd, bi, bn, bm} = 4'b0000;
    wait_ticks(6);
  endtask

  initial begin
    int c0, k;
    repeat (3) step();
    rst = 0;
    step();
    chk("reset_run", {31'b0, o_run}, 32'd1);
    chk("reset_sel", 32'(o_sel), 32'd0);
    chk("reset_wr", 32'(o_wr), 32'd0);
    chk("reset_wr_data", 32'(o_wr_data), 32'd0);
    checking = 1;
    bm = 1;
    k = 0;
    while (o_run && k < 200) begin step(); k++; end
    chk("enter_set_run", {31'b0, o_run}, 32'd0);
    chk("enter_set_sel", 32'(o_sel), 32'b100000);
    wait_ticks(2);
    bm = 0;
    wait_ticks(6);
    digits[23:20] = 4'd2;
    c0 = wr_cycles;
    press(4'b0100);
    chk("inc_d5_cycles", wr_cycles - c0, 1);
    chk("inc_d5_wr", 32'(last_wr), 32'b100000);
    chk("inc_d5_data", 32'(last_data), 32'h0);
    repeat (5) press(4'b0010);
    chk("next5_sel", 32'(o_sel), 32'b000001);
    press(4'b0010);
    chk("next6_wrap", 32'(o_sel), 32'b100000);
    repeat (5) press(4'b0010);
    digits[3:0] = 4'd0;
    press(4'b1000);
    chk("dec_d0_wr", 32'(last_wr), 32'b000001);
    chk("dec_d0_data", 32'(last_data), 32'h9);
    repeat (5) press(4'b0010);
    digits[7:4] = 4'hC;
    press(4'b0100);
    chk("inc_d1_wr", 32'(last_wr), 32'b000010);
    chk("inc_d1_data", 32'(last_data), 32'h0);
    c0 = wr_cycles;
    for (int i = 0; i < 3; i++) begin bi = ~bi; wait_ticks(1); end
    bi = 0;
    wait_ticks(8);
    chk("bounce_no_wr", wr_cycles - c0, 0);
    digits[7:4] = 4'd3;
    c0 = wr_cycles;
    press(4'b1100);
    chk("incdec_cycles", wr_cycles - c0, 1);
    chk("incdec_data", 32'(last_data), 32'h4);
    wait_ticks(52);
    chk("timeout_run", {31'b0, o_run}, 32'd1);
    chk("timeout_sel", 32'(o_sel), 32'd0);
    press(4'b0001);
    wait_ticks(30);
    chk("before_timeout_run", {31'b0, o_run}, 32'd0);
    wait_ticks(20);
    chk("after_timeout_run", {31'b0, o_run}, 32'd1);
    for (int it = 0; it < 300; it++) begin
      digits = 24'($urandom);
      bm = ($urandom_range(0, 99) < 30);
      bn = ($urandom_range(0, 99) < 30);
      bi = ($urandom_range(0, 99) < 30);
      bd = ($urandom_range(0, 99) < 30);
      wait_ticks($urandom_range(1, 10));
      {bd, bi, bn, bm} = 4'b0000;
      if ($urandom_range(0, 59) == 0) begin
        rst = 1; step(); step(); rst = 0;
      end
      wait_ticks(($urandom_range(0, 19) == 0) ? 60 : $urandom_range(6, 12));
    end
`ifdef CLOCK_SET_AUTOREPEAT_EN
    checking = 0;
    if (o_run) press(4'b0001);
    c0 = wr_cycles;
    bi = 1;
    wait_ticks(DB + RD + 2 * RP + 1);
    bi = 0;
    wait_ticks(8);
    chk("autorepeat_pulses", wr_cycles - c0, 4);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
